// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Latency: one cycle from decode inputs to every registered output; stall is combinational.
// Backpressure: stall asks fetch/decode to hold for one cycle while a bubble is inserted.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   valid_in, flush               decoded instruction present, branch/jump squash
//   rs_in, rt_in, rd_in, imm_in   instruction fields from decode
//   ctrl_in                       {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[2:0]}
//   read_data1, read_data2        register-file values for rs_in / rt_in
//   exm_*, wb_*                   EX/MEM and WB forwarding sources
//   stall                         load-use hold request (combinational)
//   valid_out, ctrl_out           latched valid and control bundle
//   rs_value, rt_value, imm_ext   forwarded operands and sign-extended immediate
//   rs_out, rt_out, dest_out      latched register numbers and selected destination
module id_ex_stage #(
    parameter int registers_width = 32,
    parameter int memory_depth    = 32,
    localparam int AW             = $clog2(memory_depth)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic                       flush,
    input  logic [AW-1:0]              rs_in,
    input  logic [AW-1:0]              rt_in,
    input  logic [AW-1:0]              rd_in,
    input  logic [15:0]                imm_in,
    input  logic [8:0]                 ctrl_in,
    input  logic [registers_width-1:0] read_data1,
    input  logic [registers_width-1:0] read_data2,
    input  logic                       exm_reg_write,
    input  logic [AW-1:0]              exm_rd,
    input  logic [registers_width-1:0] exm_result,
    input  logic                       wb_reg_write,
    input  logic [AW-1:0]              wb_rd,
    input  logic [registers_width-1:0] wb_data,
    output logic                       stall,
    output logic                       valid_out,
    output logic [registers_width-1:0] rs_value,
    output logic [registers_width-1:0] rt_value,
    output logic [registers_width-1:0] imm_ext,
    output logic [AW-1:0]              rs_out,
    output logic [AW-1:0]              rt_out,
    output logic [AW-1:0]              dest_out,
    output logic [8:0]                 ctrl_out
);

    // Control bundle bit positions
    localparam int REG_WRITE = 8;
    localparam int MEM_READ  = 7;
    localparam int REG_DST   = 3;

    logic [registers_width-1:0] rs_fwd;
    logic [registers_width-1:0] rt_fwd;
    logic [registers_width-1:0] imm_sext;
    logic [AW-1:0]              dest_sel;
    logic                       bubble;

    // Load in EX whose destination is read by the instruction now in decode:
    // the loaded value is not available for forwarding until next cycle.
    always_comb begin
        stall = valid_out && ctrl_out[MEM_READ] && (dest_out != '0) && valid_in &&
                ((dest_out == rs_in) || (dest_out == rt_in));
    end

    // EX/MEM is the younger producer, so it wins over WB. Register 0 is
    // hard-wired and never forwarded.
    always_comb begin
        rs_fwd = read_data1;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs_in))
            rs_fwd = exm_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_in))
            rs_fwd = wb_data;

        rt_fwd = read_data2;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rt_in))
            rt_fwd = exm_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_in))
            rt_fwd = wb_data;
    end

    // A non-writing instruction reports destination 0 so downstream hazard
    // and forwarding compares never match it.
    always_comb begin
        dest_sel = '0;
        if (ctrl_in[REG_WRITE])
            dest_sel = ctrl_in[REG_DST] ? rd_in : rt_in;
    end

    assign imm_sext = {{(registers_width-16){imm_in[15]}}, imm_in};
    assign bubble   = flush || stall || !valid_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            ctrl_out  <= '0;
            dest_out  <= '0;
            rs_out    <= '0;
            rt_out    <= '0;
            rs_value  <= '0;
            rt_value  <= '0;
            imm_ext   <= '0;
        end else if (bubble) begin
            // Bubble kills only the fields that give the slot meaning;
            // operand data is left as-is.
            valid_out <= 1'b0;
            ctrl_out  <= '0;
            dest_out  <= '0;
        end else begin
            valid_out <= 1'b1;
            ctrl_out  <= ctrl_in;
            dest_out  <= dest_sel;
            rs_out    <= rs_in;
            rt_out    <= rt_in;
            rs_value  <= rs_fwd;
            rt_value  <= rt_fwd;
            imm_ext   <= imm_sext;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, flush;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [15:0] imm_in;
    logic [8:0]  ctrl_in;
    logic [31:0] read_data1, read_data2;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, valid_out;
    logic [31:0] rs_value, rt_value, imm_ext;
    logic [4:0]  rs_out, rt_out, dest_out;
    logic [8:0]  ctrl_out;

    int tests = 0;
    int fails = 0;

    // Expected pipeline-register contents
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [4:0]  m_dest, m_rs, m_rt;
    logic [31:0] m_rsv, m_rtv, m_imm;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .imm_in(imm_in), .ctrl_in(ctrl_in),
        .read_data1(read_data1), .read_data2(read_data2),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .valid_out(valid_out), .rs_value(rs_value), .rt_value(rt_value),
        .imm_ext(imm_ext), .rs_out(rs_out), .rt_out(rt_out), .dest_out(dest_out),
        .ctrl_out(ctrl_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        if (exm_reg_write && exm_rd == r) return exm_result;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return rf;
    endfunction

    function automatic logic model_stall();
        // load (mem_read, ctrl bit 7) in EX feeding an operand of the decoding instruction
        return m_valid && m_ctrl[7] && m_dest != 5'd0 && valid_in &&
               (m_dest == rs_in || m_dest == rt_in);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = 0; m_dest = 0; m_rs = 0; m_rt = 0;
        m_rsv = 0; m_rtv = 0; m_imm = 0;
    endtask

    task automatic model_edge(input logic st);
        if (flush || st || !valid_in) begin
            m_valid = 0; m_ctrl = 0; m_dest = 0;
        end else begin
            m_valid = 1;
            m_ctrl  = ctrl_in;
            m_dest  = !ctrl_in[8] ? 5'd0 : (ctrl_in[3] ? rd_in : rt_in);
            m_rs    = rs_in;
            m_rt    = rt_in;
            m_rsv   = fwd(rs_in, read_data1);
            m_rtv   = fwd(rt_in, read_data2);
            m_imm   = {{16{imm_in[15]}}, imm_in};
        end
    endtask

    task automatic check_all();
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("ctrl_out",  32'(ctrl_out),  32'(m_ctrl));
        check("dest_out",  32'(dest_out),  32'(m_dest));
        check("rs_out",    32'(rs_out),    32'(m_rs));
        check("rt_out",    32'(rt_out),    32'(m_rt));
        check("rs_value",  rs_value,       m_rsv);
        check("rt_value",  rt_value,       m_rtv);
        check("imm_ext",   imm_ext,        m_imm);
    endtask

    // Inputs are already driven; check stall, clock one edge, check outputs.
    task automatic step();
        logic st;
        #1;
        st = model_stall();
        check("stall", 32'(stall), 32'(st));
        @(posedge clk);
        model_edge(st);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        valid_in = 0; flush = 0; rs_in = 0; rt_in = 0; rd_in = 0; imm_in = 0; ctrl_in = 0;
        read_data1 = 0; read_data2 = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        model_reset();
        #1;
        check_all();
        check("stall_in_reset", 32'(stall), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;

        // Load some nonzero state, then reset between edges
        valid_in = 1; ctrl_in = 9'h1FF; rs_in = 3; rt_in = 4; rd_in = 5;
        imm_in = 16'h1234; read_data1 = 32'h11; read_data2 = 32'h22;
        step();
        #2;
        reset = 1;
        model_reset();
        #1;
        check_all();
        check("stall_after_async_reset", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check_all();
        reset = 0;

        // Sign extension, first capture after release
        clear_inputs();
        valid_in = 1; ctrl_in = 9'h010; imm_in = 16'hFFF0;
        step();
        check("imm_neg", imm_ext, 32'hFFFFFFF0);
        check("valid_first", 32'(valid_out), 32'd1);

        // EX/MEM forwarding beats WB
        clear_inputs();
        valid_in = 1; ctrl_in = 9'h100; rs_in = 5; read_data1 = 32'h5555;
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'hAAAA0000;
        wb_reg_write = 1; wb_rd = 5; wb_data = 32'h1;
        step();
        check("fwd_exm_prio", rs_value, 32'hAAAA0000);

        // Register 0 never forwarded
        clear_inputs();
        valid_in = 1; rt_in = 0; exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'hBEEF;
        step();
        check("no_fwd_r0", rt_value, 32'd0);

        // Load-use: lw $8, then consumer of $8
        clear_inputs();
        valid_in = 1; ctrl_in = 9'h180; rt_in = 8; rs_in = 1;
        step();
        check("lw_dest", 32'(dest_out), 32'd8);
        ctrl_in = 9'h108; rs_in = 8; rt_in = 2; rd_in = 9;
        step();
        check("lu_bubble_valid", 32'(valid_out), 32'd0);
        step();
        check("lu_capture_valid", 32'(valid_out), 32'd1);
        check("lu_capture_dest", 32'(dest_out), 32'd9);

        // Load-use with flush at the same time: one bubble, no extra stall
        ctrl_in = 9'h180; rt_in = 8; rs_in = 1;
        step();
        flush = 1; ctrl_in = 9'h108; rs_in = 8;
        step();
        flush = 0;
        step();
        check("flush_stall_recover", 32'(valid_out), 32'd1);

        // Flush squashes a writing instruction
        valid_in = 1; flush = 1; ctrl_in = 9'h108; rd_in = 7;
        step();
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_ctrl", 32'(ctrl_out), 32'd0);
        flush = 0;

        // Destination selection
        clear_inputs();
        valid_in = 1; ctrl_in = 9'h100; rt_in = 9; rd_in = 3;
        step();
        check("dest_rt", 32'(dest_out), 32'd9);
        ctrl_in = 9'h000;
        step();
        check("dest_nowrite", 32'(dest_out), 32'd0);

        // Randomized traffic with small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            valid_in      = ($urandom_range(0, 9) < 8);
            flush         = ($urandom_range(0, 9) == 0);
            rs_in         = 5'($urandom_range(0, 7));
            rt_in         = 5'($urandom_range(0, 7));
            rd_in         = 5'($urandom_range(0, 7));
            imm_in        = 16'($urandom);
            ctrl_in       = 9'($urandom);
            read_data1    = $urandom;
            read_data2    = $urandom;
            exm_reg_write = 1'($urandom);
            exm_rd        = 5'($urandom_range(0, 7));
            exm_result    = $urandom;
            wb_reg_write  = 1'($urandom);
            wb_rd         = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
